// File: rtl/reg_file_2r1w.sv
// Parametrised DEPTH x WIDTH register file with one write port and two registered read ports.
// Entry 0 can be hardwired to zero, and a sequencer clears one entry per cycle on request.
module reg_file_2r1w #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter bit ZERO_REG0 = 1'b1,
    parameter bit BYPASS    = 1'b1,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              valid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              valid_b,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  clr_cnt_r;
    logic [ADDR_W-1:0]  clr_cnt_nxt_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic               wr_accept_s;
    logic               rd_fire_a_s;
    logic               rd_fire_b_s;
    logic [WIDTH-1:0]   rd_val_a_s;
    logic [WIDTH-1:0]   rd_val_b_s;
    logic [WIDTH-1:0]   rdata_a_r;
    logic [WIDTH-1:0]   rdata_b_r;
    logic               valid_a_r;
    logic               valid_b_r;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_EXT);
    endfunction

    function automatic logic addr_backed(input logic [ADDR_W-1:0] addr);
        return addr_in_range(addr) && !(ZERO_REG0 && (addr == '0));
    endfunction

    // Port-level qualifiers: nothing is accepted while the clear runs or is being requested.
    always_comb begin
        wr_accept_s = (state_r == ST_IDLE) && !clr && we && addr_backed(waddr);
        rd_fire_a_s = (state_r == ST_IDLE) && !clr && re_a;
        rd_fire_b_s = (state_r == ST_IDLE) && !clr && re_b;
    end

    // Read value for port A, including same-edge forwarding of an accepted write.
    always_comb begin
        rd_val_a_s = '0;
        if (!addr_backed(raddr_a)) begin
            rd_val_a_s = '0;
        end else if (BYPASS && wr_accept_s && (waddr == raddr_a)) begin
            rd_val_a_s = wdata;
        end else begin
            rd_val_a_s = mem_r[raddr_a];
        end
    end

    // Read value for port B, identical rules to port A.
    always_comb begin
        rd_val_b_s = '0;
        if (!addr_backed(raddr_b)) begin
            rd_val_b_s = '0;
        end else if (BYPASS && wr_accept_s && (waddr == raddr_b)) begin
            rd_val_b_s = wdata;
        end else begin
            rd_val_b_s = mem_r[raddr_b];
        end
    end

    // Clear sequencer next-state: one entry per cycle, leaving on the last entry.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clr) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = '0;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Storage array: cleared entry by entry during CLEAR, written only when IDLE.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (wr_accept_s) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[0] <= mem_r[0];
        end
    end

    // Registered read ports; data holds when a port does not fire.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rdata_a_r <= '0;
            rdata_b_r <= '0;
            valid_a_r <= 1'b0;
            valid_b_r <= 1'b0;
        end else begin
            valid_a_r <= rd_fire_a_s;
            valid_b_r <= rd_fire_b_s;
            if (rd_fire_a_s) begin
                rdata_a_r <= rd_val_a_s;
            end
            if (rd_fire_b_s) begin
                rdata_b_r <= rd_val_b_s;
            end
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
    assign valid_a = valid_a_r;
    assign valid_b = valid_b_r;
    assign busy    = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a default instance (DEPTH 32, zero reg, bypass) and a DEPTH 20
// instance without zero reg or bypass, driven by shared inputs and checked against a model.
module tb_reg_file_2r1w;

    logic        CLK = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re_a;
    logic [4:0]  raddr_a;
    logic        re_b;
    logic [4:0]  raddr_b;
    logic        clr;

    logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic        valid_a0, valid_b0, valid_a1, valid_b1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    reg_file_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG0(1'b1), .BYPASS(1'b1)) u_main (
        .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .valid_a(valid_a0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .valid_b(valid_b0),
        .clr(clr), .busy(busy0)
    );

    reg_file_2r1w #(.WIDTH(32), .DEPTH(20), .ZERO_REG0(1'b0), .BYPASS(1'b0)) u_alt (
        .CLK(CLK), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .valid_a(valid_a1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .valid_b(valid_b1),
        .clr(clr), .busy(busy1)
    );

    // Reference model: plain array per instance plus a clear position (-1 when idle).
    logic [31:0] mm [2][32];
    int          cpos [2];
    int          dep  [2] = '{32, 20};
    bit          zr   [2] = '{1'b1, 1'b0};
    bit          bp   [2] = '{1'b1, 1'b0};
    logic [31:0] era [2], erb [2];
    logic        eva [2], evb [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
            cpos[k] = -1;
            era[k] = 32'h0; erb[k] = 32'h0; eva[k] = 1'b0; evb[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] read_val(int k, int addr, bit wr_ok);
        if (addr >= dep[k] || (zr[k] && addr == 0)) return 32'h0;
        if (bp[k] && wr_ok && int'(waddr) == addr) return wdata;
        return mm[k][addr];
    endfunction

    task automatic model_edge(int k);
        bit wr_ok;
        if (cpos[k] >= 0) begin
            mm[k][cpos[k]] = 32'h0;
            cpos[k]++;
            if (cpos[k] == dep[k]) cpos[k] = -1;
            eva[k] = 1'b0; evb[k] = 1'b0;
        end else if (clr) begin
            cpos[k] = 0;
            eva[k] = 1'b0; evb[k] = 1'b0;
        end else begin
            wr_ok = we && (int'(waddr) < dep[k]) && !(zr[k] && waddr == 5'd0);
            eva[k] = re_a; evb[k] = re_b;
            if (re_a) era[k] = read_val(k, int'(raddr_a), wr_ok);
            if (re_b) erb[k] = read_val(k, int'(raddr_b), wr_ok);
            if (wr_ok) mm[k][waddr] = wdata;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        chk("main_rdata_a", rdata_a0, era[0]);
        chk("main_valid_a", {31'h0, valid_a0}, {31'h0, eva[0]});
        chk("main_rdata_b", rdata_b0, erb[0]);
        chk("main_valid_b", {31'h0, valid_b0}, {31'h0, evb[0]});
        chk("main_busy", {31'h0, busy0}, {31'h0, cpos[0] >= 0});
        chk("alt_rdata_a", rdata_a1, era[1]);
        chk("alt_valid_a", {31'h0, valid_a1}, {31'h0, eva[1]});
        chk("alt_rdata_b", rdata_b1, erb[1]);
        chk("alt_valid_b", {31'h0, valid_b1}, {31'h0, evb[1]});
        chk("alt_busy", {31'h0, busy1}, {31'h0, cpos[1] >= 0});
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        re_a = 1'b0; raddr_a = 5'd0; re_b = 1'b0; raddr_b = 5'd0; clr = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re_a;
        logic [4:0]  raddr_a;
        logic        re_b;
        logic [4:0]  raddr_b;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic        va, vb;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cnt0, cnt1;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd7,  32'h1,         1'b0, 5'd0,  1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd7,  32'h4,         1'b1, 5'd7,  1'b0, 5'd0,  32'h4, 32'h0, 32'h1, 32'h1234, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd7,  32'h4, 32'h4, 32'h4, 32'h4, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 5'd25, 32'hFFFF_FFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h4, 32'h4, 32'h4, 32'h4, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd25, 1'b1, 5'd19, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 5'd19, 32'h19,        1'b1, 5'd19, 1'b1, 5'd31, 32'h19, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b1, 5'd19, 32'h19, 32'h19, 32'h0, 32'h19, 1'b0, 1'b1};

        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        chk("reset_busy", {30'h0, busy0, busy1}, 32'h0);
        chk("reset_valid", {28'h0, valid_a0, valid_b0, valid_a1, valid_b1}, 32'h0);
        chk("reset_rdata", rdata_a0 | rdata_b0 | rdata_a1 | rdata_b1, 32'h0);
        @(negedge CLK);
        reset = 1'b0;

        // Directed vectors: basic write/read, zero register, bypass, out-of-range address.
        for (int v = 0; v < 12; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            re_a = vecs[v].re_a; raddr_a = vecs[v].raddr_a;
            re_b = vecs[v].re_b; raddr_b = vecs[v].raddr_b; clr = 1'b0;
            tick();
            chk("vec_main_rdata_a", rdata_a0, vecs[v].ra0);
            chk("vec_main_rdata_b", rdata_b0, vecs[v].rb0);
            chk("vec_alt_rdata_a", rdata_a1, vecs[v].ra1);
            chk("vec_alt_rdata_b", rdata_b1, vecs[v].rb1);
            chk("vec_valid_a", {30'h0, valid_a0, valid_a1}, {30'h0, vecs[v].va, vecs[v].va});
            chk("vec_valid_b", {30'h0, valid_b0, valid_b1}, {30'h0, vecs[v].vb, vecs[v].vb});
        end

        // Bulk clear: fill, request clear alongside a write, measure busy length, read back zeros.
        for (int a = 1; a < 32; a++) begin
            idle_inputs();
            we = 1'b1; waddr = 5'(a); wdata = $urandom | 32'h1;
            tick();
        end
        idle_inputs();
        clr = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF; re_a = 1'b1; raddr_a = 5'd3;
        tick();
        cnt0 = busy0 ? 1 : 0;
        cnt1 = busy1 ? 1 : 0;
        for (int g = 0; g < 100 && (busy0 || busy1); g++) begin
            idle_inputs();
            clr = (g == 5);
            we = (g < 15); waddr = 5'($urandom_range(0, 31)); wdata = $urandom;
            re_a = 1'b1; raddr_a = 5'($urandom_range(0, 31));
            re_b = 1'b1; raddr_b = 5'($urandom_range(0, 31));
            tick();
            if (busy0) cnt0++;
            if (busy1) cnt1++;
        end
        chk("main_busy_cycles", 32'(cnt0), 32'd32);
        chk("alt_busy_cycles", 32'(cnt1), 32'd20);
        for (int a = 0; a < 32; a++) begin
            idle_inputs();
            re_a = 1'b1; raddr_a = 5'(a); re_b = 1'b1; raddr_b = 5'(31 - a);
            tick();
            chk("post_clear_zero", rdata_a0 | rdata_b0 | rdata_a1 | rdata_b1, 32'h0);
        end

        // Reset asserted in the middle of a clear.
        idle_inputs();
        we = 1'b1; waddr = 5'd9; wdata = 32'h5555_0009;
        tick();
        idle_inputs();
        re_a = 1'b1; raddr_a = 5'd9;
        tick();
        idle_inputs();
        clr = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("midclear_reset_busy", {30'h0, busy0, busy1}, 32'h0);
        chk("midclear_reset_valid", {28'h0, valid_a0, valid_b0, valid_a1, valid_b1}, 32'h0);
        chk("midclear_reset_rdata", rdata_a0 | rdata_b0 | rdata_a1 | rdata_b1, 32'h0);
        @(negedge CLK);
        reset = 1'b0;
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
        tick();
        idle_inputs();
        re_a = 1'b1; raddr_a = 5'd9; re_b = 1'b1; raddr_b = 5'd4;
        tick();
        chk("after_reset_read", rdata_a0, 32'hA5A5_A5A5);
        chk("after_reset_alt_read", rdata_a1, 32'hA5A5_A5A5);

        // Randomised traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            we = ($urandom_range(0, 1) == 1);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            re_a = ($urandom_range(0, 4) < 3);
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            re_b = ($urandom_range(0, 4) < 3);
            raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 5'($urandom_range(0, 31));
            clr = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
